uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and
// frame-format defaults used by both the transmitter and the receiver.
package uart_pkg;

    // Baud-rate oversampling: s_tick pulses per bit time.
    localparam int OVERSAMPLE = 16;

    // Default frame format: 8 data bits, 1 stop bit (16 ticks).
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

    // FSM encodings, kept as plain constants so the receiver can reuse them.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

    // Terminal value of the 5-bit tick counter for an interval of `ticks`.
    function automatic logic [4:0] last_tick(input int ticks);
        return 5'(ticks - 1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a data source and the UART transmitter.
// The source presents din with tx_valid; the transmitter accepts on any
// clock edge where tx_valid and tx_ready are both high.
interface uart_tx_if;

    logic       tx_valid;
    logic [7:0] din;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output din,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  din,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first serialiser timed by a shared baud x16 tick.
// A one-entry holding register decouples the byte source from the frame
// in flight so consecutive frames follow each other with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,     // data bits per frame, 5..8
    parameter int SB_TICK = DEF_SB_TICK   // stop-bit length in s_tick pulses
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     s_tick,
    uart_tx_if.slave host,
    output logic     tx_done_tick,
    output logic     tx_busy,
    output logic     tx
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DBIT < 5 || DBIT > 8) begin : g_bad_dbit
        $error("uart_tx: DBIT must be in 5..8");
    end
    if (SB_TICK < 1 || SB_TICK > 32) begin : g_bad_sb_tick
        $error("uart_tx: SB_TICK must be in 1..32");
    end

    localparam logic [4:0] BIT_LAST  = last_tick(OVERSAMPLE);
    localparam logic [4:0] STOP_LAST = last_tick(SB_TICK);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [4:0] s_reg,     s_next;      // tick counter within a bit
    logic [2:0] n_reg,     n_next;      // data bit index
    logic [7:0] shift_reg, shift_next;  // bits still to be sent, LSB next
    logic       tx_reg,    tx_next;     // registered line value

    logic [7:0] hold_reg;               // queued byte
    logic       hold_full;              // queued byte present
    logic       accept;                 // handshake completes this edge
    logic       load;                   // FSM takes the queued byte this edge

    assign accept        = host.tx_valid && host.tx_ready;
    assign host.tx_ready = ~hold_full;

    // Holding register: fill on handshake, empty when the FSM loads it.
    // NOTE: the data register is reset along with its flag so an aborted
    // byte can never leak into a later frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= host.din;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // FSM and datapath registers; tx leaves the block only through tx_reg.
    // NOTE: non-blocking assignments here so every register samples the
    // values computed for this edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // Next-state, datapath update and frame-done strobe.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        load         = 1'b0;
        tx_done_tick = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (hold_full) begin
                    load       = 1'b1;
                    shift_next = hold_reg;
                    s_next     = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                        tx_next    = shift_reg[0];
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_reg == BIT_LAST) begin
                        s_next     = '0;
                        shift_next = shift_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end else begin
                            n_next  = n_reg + 3'd1;
                            tx_next = shift_reg[1];
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        s_next       = '0;
                        if (hold_full) begin
                            // Chain straight into the next start bit.
                            load       = 1'b1;
                            shift_next = hold_reg;
                            state_next = START;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx_busy = (state_reg != IDLE);
    assign tx      = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an 8N1 instance and a 7-bit / 2-stop-bit
// instance share one baud x16 tick. A tick-driven loopback receiver
// decodes frames; a negedge monitor timestamps tx edges and done pulses.
module tb_uart_tx;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic s_tick = 1'b0;
    bit   tick_en = 1'b1;
    int   tick_div = 0;

    logic done_a, busy_a, tx_a;
    logic done_b, busy_b, tx_b;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    logic tx_a_q = 1'b1;
    logic tx_b_q = 1'b1;
    int edges_a[$];
    int edges_b[$];
    int done_a_q[$];
    int done_b_q[$];

    uart_tx_if bus_a ();
    uart_tx_if bus_b ();

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick), .host(bus_a),
        .tx_done_tick(done_a), .tx_busy(busy_a), .tx(tx_a)
    );

    uart_tx #(.DBIT(7), .SB_TICK(32)) dut_b (
        .clk(clk), .reset(reset), .s_tick(s_tick), .host(bus_b),
        .tx_done_tick(done_b), .tx_busy(busy_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    // Baud x16 tick: one clk wide every 16 clk, frozen while tick_en is low.
    always @(posedge clk) begin
        if (tick_en && tick_div == 15) begin
            tick_div <= 0;
            s_tick   <= 1'b1;
        end else begin
            if (tick_en) tick_div <= tick_div + 1;
            s_tick <= 1'b0;
        end
    end

    // Edge and done-pulse timestamps, sampled mid-cycle.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        tx_a_q <= tx_a;
        tx_b_q <= tx_b;
        if (tx_a !== tx_a_q) edges_a.push_back(cyc);
        if (tx_b !== tx_b_q) edges_b.push_back(cyc);
        if (done_a === 1'b1) done_a_q.push_back(cyc);
        if (done_b === 1'b1) done_b_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic ready(input bit sel);
        return sel ? bus_b.tx_ready : bus_a.tx_ready;
    endfunction

    function automatic int edge_at(input bit sel, input int i);
        if (sel) return (i < edges_b.size()) ? edges_b[i] : -100000;
        return (i < edges_a.size()) ? edges_a[i] : -100000;
    endfunction

    task automatic set_valid(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            bus_b.tx_valid = v;
            bus_b.din      = d;
        end else begin
            bus_a.tx_valid = v;
            bus_a.din      = d;
        end
    endtask

    task automatic clear_logs();
        @(negedge clk);
        #1;
        edges_a.delete();
        edges_b.delete();
        done_a_q.delete();
        done_b_q.delete();
    endtask

    // Present one byte and hold it until the edge that accepts it.
    task automatic send(input bit sel, input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        set_valid(sel, 1'b1, b);
        while (ready(sel) !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("send_accept_wait", 32'(guard < 5000), 32'd1);
        @(negedge clk);
        set_valid(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_ticks(input int n, output bit ok);
        int seen  = 0;
        int guard = 0;
        ok = 1'b1;
        while (seen < n) begin
            @(negedge clk);
            if (s_tick) seen++;
            guard++;
            if (guard > n * 16 + 2000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Loopback receiver: find the start edge, sample at bit centres.
    task automatic rx_frame(input bit sel, input int dbit, output logic [7:0] data, output bit ok);
        int guard = 0;
        bit t_ok;
        data = '0;
        ok   = 1'b1;
        while (line(sel) !== 1'b0 && ok) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) ok = 1'b0;
        end
        if (ok) begin
            wait_ticks(8, t_ok);
            ok &= t_ok;
            if (line(sel) !== 1'b0) ok = 1'b0;
            for (int i = 0; i < dbit; i++) begin
                wait_ticks(16, t_ok);
                ok &= t_ok;
                data[i] = line(sel);
            end
            wait_ticks(16, t_ok);
            ok &= t_ok;
            if (line(sel) !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d0, d1;
        bit ok0, ok1, t_ok;
        int g;
        int n_before;

        set_valid(1'b0, 1'b0, 8'h00);
        set_valid(1'b1, 1'b0, 8'h00);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        // ---- reset state ----
        check("rst_tx",    32'(tx_a),           32'd1);
        check("rst_ready", 32'(bus_a.tx_ready), 32'd1);
        check("rst_done",  32'(done_a),         32'd0);
        check("rst_busy",  32'(busy_a),         32'd0);
        check("rst_tx_b",  32'(tx_b),           32'd1);

        // ---- 1: single frame 0xA5 ----
        clear_logs();
        @(negedge clk);
        set_valid(1'b0, 1'b1, 8'hA5);
        @(negedge clk);                       // accept edge has passed
        set_valid(1'b0, 1'b0, 8'h00);
        check("t1_ready_after_accept", 32'(bus_a.tx_ready), 32'd0);
        check("t1_tx_after_accept",    32'(tx_a),           32'd1);
        @(negedge clk);                       // load edge has passed
        check("t1_tx_start",  32'(tx_a),           32'd0);
        check("t1_ready_ret", 32'(bus_a.tx_ready), 32'd1);
        check("t1_busy",      32'(busy_a),         32'd1);
        rx_frame(1'b0, 8, d0, ok0);
        repeat (300) @(negedge clk);
        check("t1_rx_ok",    32'(ok0), 32'd1);
        check("t1_rx_data",  32'(d0),  32'hA5);
        check("t1_edges",    32'(edges_a.size()), 32'd8);
        check("t1_start_len",
              32'((edge_at(0, 1) - edge_at(0, 0)) inside {[241:256]}), 32'd1);
        check("t1_bit0_len", 32'(edge_at(0, 2) - edge_at(0, 1)), 32'd256);
        check("t1_bit34_len", 32'(edge_at(0, 5) - edge_at(0, 4)), 32'd512);
        check("t1_bits0to6", 32'(edge_at(0, 7) - edge_at(0, 1)), 32'd1792);
        check("t1_done_cnt", 32'(done_a_q.size()), 32'd1);
        check("t1_done_time", 32'(done_a_q.size() > 0 ? done_a_q[0] : -1),
              32'(edge_at(0, 1) + 2303));
        check("t1_idle_busy", 32'(busy_a), 32'd0);

        // ---- 2: back-to-back 0x55 then 0x0F ----
        clear_logs();
        fork
            begin
                rx_frame(1'b0, 8, d0, ok0);
                rx_frame(1'b0, 8, d1, ok1);
            end
            begin
                send(1'b0, 8'h55);
                repeat (1000) @(negedge clk);
                send(1'b0, 8'h0F);
            end
        join
        repeat (300) @(negedge clk);
        check("t2_rx_ok",   32'(ok0 & ok1), 32'd1);
        check("t2_rx_d0",   32'(d0), 32'h55);
        check("t2_rx_d1",   32'(d1), 32'h0F);
        check("t2_edges",   32'(edges_a.size()), 32'd14);
        check("t2_stop_len", 32'(edge_at(0, 10) - edge_at(0, 9)), 32'd256);
        check("t2_done_at_start", 32'(done_a_q.size() > 0 ? done_a_q[0] : -1),
              32'(edge_at(0, 10) - 1));
        check("t2_f2_bits0to3", 32'(edge_at(0, 12) - edge_at(0, 11)), 32'd1024);
        check("t2_done_cnt", 32'(done_a_q.size()), 32'd2);

        // ---- 3: tx_valid held high, din changing every clk ----
        clear_logs();
        fork
            begin
                rx_frame(1'b0, 8, d0, ok0);
                rx_frame(1'b0, 8, d1, ok1);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 40; k++) begin
                    set_valid(1'b0, 1'b1, 8'h30 + 8'(k));
                    @(negedge clk);
                end
                set_valid(1'b0, 1'b0, 8'h00);
            end
        join
        repeat (3000) @(negedge clk);
        check("t3_rx_ok",    32'(ok0 & ok1), 32'd1);
        check("t3_rx_d0",    32'(d0), 32'h30);
        check("t3_rx_d1",    32'(d1), 32'h32);
        check("t3_done_cnt", 32'(done_a_q.size()), 32'd2);
        check("t3_idle_tx",  32'(tx_a), 32'd1);
        check("t3_idle_rdy", 32'(bus_a.tx_ready), 32'd1);

        // ---- 4: reset during bit 3 of 0xC3 with 0x99 queued ----
        clear_logs();
        send(1'b0, 8'hC3);
        send(1'b0, 8'h99);
        check("t4_queued", 32'(bus_a.tx_ready), 32'd0);
        wait_ticks(70, t_ok);
        check("t4_tick_wait", 32'(t_ok), 32'd1);
        check("t4_bit3_low",  32'(tx_a), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t4_async_tx",   32'(tx_a),           32'd1);
        check("t4_rst_busy",   32'(busy_a),         32'd0);
        check("t4_rst_ready",  32'(bus_a.tx_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (3000) @(negedge clk);
        check("t4_no_frame", 32'(edges_a.size()),  32'd0);
        check("t4_no_done",  32'(done_a_q.size()), 32'd0);
        check("t4_tx_idle",  32'(tx_a), 32'd1);

        // ---- 5: DBIT=7, SB_TICK=32, 0x7F ----
        clear_logs();
        send(1'b1, 8'h7F);
        rx_frame(1'b1, 7, d0, ok0);
        repeat (600) @(negedge clk);
        check("t5_rx_ok",   32'(ok0), 32'd1);
        check("t5_rx_data", 32'(d0),  32'h7F);
        check("t5_edges",   32'(edges_b.size()), 32'd2);
        check("t5_done_cnt", 32'(done_b_q.size()), 32'd1);
        check("t5_stop_end", 32'(done_b_q.size() > 0 ? done_b_q[0] : -1),
              32'(edge_at(1, 1) + 1792 + 512 - 1));
        check("t5_busy_end", 32'(busy_b), 32'd0);

        // ---- 6: s_tick stalled for 1000 clk inside bit 2 of 0x3C ----
        clear_logs();
        fork
            rx_frame(1'b0, 8, d0, ok0);
            begin
                send(1'b0, 8'h3C);
                g = 0;
                while (edges_a.size() < 2 && g < 10000) begin
                    @(negedge clk);
                    g++;
                end
                check("t6_reach_bit2", 32'(g < 10000), 32'd1);
                repeat (100) @(negedge clk);
                n_before = edges_a.size();
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                tick_en = 1'b1;
                check("t6_pause_tx",    32'(tx_a), 32'd1);
                check("t6_pause_edges", 32'(edges_a.size()), 32'(n_before));
            end
        join
        repeat (300) @(negedge clk);
        check("t6_rx_ok",    32'(ok0), 32'd1);
        check("t6_rx_data",  32'(d0),  32'h3C);
        check("t6_edges",    32'(edges_a.size()), 32'd4);
        check("t6_ones_len", 32'(edge_at(0, 2) - edge_at(0, 1)), 32'(4 * 256 + 1000));
        check("t6_done_cnt", 32'(done_a_q.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
